// File: rtl/sm_div_seq_if.sv
// Start/busy/done handshake and operand/result bundle for the sign-magnitude divider.
// The master drives the request; the slave (divider) returns the results.
interface sm_div_seq_if #(
    parameter int unsigned W = 3
);
    logic             start;
    logic [2*W-2:0]   dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*W-2:0]   quot;
    logic [W-1:0]     rem;
    logic             div0;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quot, rem, div0
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quot, rem, div0
    );
endinterface

// File: rtl/sm_div_seq.sv
// Sequential sign-magnitude restoring divider, one quotient bit per cycle.
// Divides a (2W-1)-bit product-format dividend by a W-bit divisor.
module sm_div_seq #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    sm_div_seq_if.slave  bus
);
    localparam int unsigned N  = 2 * W - 2;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-2:0]   r_prem;
    logic [N-1:0]   r_dvd;
    logic [W-2:0]   r_dsr;
    logic           r_qsign;
    logic           r_rsign;
    logic           r_busy;
    logic           r_done;
    logic [N:0]     r_quot;
    logic [W-1:0]   r_rem;
    logic           r_div0;

    logic [W-1:0]   w_prem_sh;
    logic           w_ge;
    logic [W-2:0]   w_diff;
    logic [W-2:0]   w_prem_nx;
    logic [N-1:0]   w_dvd_nx;
    logic           w_in_qsign;
    logic           w_in_dsr_zero;

    // Partial remainder stays below the divisor, so W-1 bits hold it between steps;
    // the shifted value needs one extra bit before the trial subtract.
    always_comb begin
        w_prem_sh     = {r_prem, r_dvd[N-1]};
        w_ge          = (w_prem_sh >= {1'b0, r_dsr});
        w_diff        = w_prem_sh[W-2:0] - r_dsr;
        w_prem_nx     = w_ge ? w_diff : w_prem_sh[W-2:0];
        w_dvd_nx      = {r_dvd[N-2:0], w_ge};
        w_in_qsign    = bus.dividend[N] ^ bus.divisor[W-1];
        w_in_dsr_zero = (bus.divisor[W-2:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_prem  <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_div0  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_qsign <= w_in_qsign;
                        r_rsign <= bus.dividend[N];
                        r_dvd   <= bus.dividend[N-1:0];
                        r_dsr   <= bus.divisor[W-2:0];
                        r_prem  <= '0;
                        r_cnt   <= CW'(N - 1);
                        if (w_in_dsr_zero) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_div0  <= 1'b1;
                            r_quot  <= {w_in_qsign, {N{1'b1}}};
                            r_rem   <= '0;
                        end else begin
                            r_state <= StRun;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    r_prem <= w_prem_nx;
                    r_dvd  <= w_dvd_nx;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_div0  <= 1'b0;
                        // Zero magnitudes never carry a sign bit.
                        r_quot  <= {(|w_dvd_nx) & r_qsign, w_dvd_nx};
                        r_rem   <= {(|w_prem_nx) & r_rsign, w_prem_nx};
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.quot = r_quot;
    assign bus.rem  = r_rem;
    assign bus.div0 = r_div0;
endmodule
